// File: rtl/pic_pkg.sv
// Shared types for the interrupt priority / in-service block: FSM states, 3-bit level, reset constants.
package pic_pkg;

  typedef enum logic {ST_IDLE, ST_ACK1} pic_state_t;

  typedef logic [2:0] level_t;

  localparam level_t LOWEST_PTR_RESET = 3'd7;
  localparam level_t LEVEL_SPURIOUS   = 3'd7;

  function automatic logic [7:0] level_onehot(input level_t lvl);
    return 8'b0000_0001 << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_encoder.sv
// Rotated priority encoder: level (i_lowest_ptr+1) mod 8 ranks highest; o_rank 0 = highest priority.
// Purely combinational, zero latency, no flow control.
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [7:0] i_vec,
  input  level_t     i_lowest_ptr,
  output logic       o_vld,
  output level_t     o_level,
  output level_t     o_rank
);

  // Walk from lowest to highest priority so the last hit (highest priority) wins.
  always_comb begin
    o_vld   = 1'b0;
    o_level = '0;
    o_rank  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i_vec[level_t'(i_lowest_ptr + 3'd1 + level_t'(i))]) begin
        o_vld   = 1'b1;
        o_level = level_t'(i_lowest_ptr + 3'd1 + level_t'(i));
        o_rank  = level_t'(i);
      end
    end
  end

endmodule

// File: rtl/priority_in_service.sv
// 8259-style priority resolver + in-service register with two-pulse INTA sequencing; vector/clear outputs one cycle after each ack edge.
// No backpressure; optional priority rotation on EOI is built only with PIC_PRIORITY_ROTATE_EN defined.
module priority_in_service
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt_req_register,
  input  logic [7:0] interrupt_mask,
  input  logic       inta_n,
  input  logic       eoi_cmd,
  input  logic       seoi_cmd,
  input  logic [2:0] seoi_level,
  input  logic       aeoi_mode,
  input  logic       rotate_on_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] clear_interrupt_req,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  pic_state_t r_state, w_state_nxt;
  logic       r_inta_n_q;
  logic [7:0] r_isr;
  logic [7:0] r_clear;
  logic [7:0] r_vector;
  logic       r_vector_vld;
  level_t     r_pending;
  logic       r_spurious;
  level_t     w_lowest_ptr;

  logic       w_ack_edge, w_ack1, w_ack2;
  logic [7:0] w_eligible;
  logic       w_req_vld, w_isr_vld, w_winner_vld;
  level_t     w_req_level, w_req_rank, w_isr_level, w_isr_rank;
  logic       w_aeoi_clr, w_eoi_clr;
  logic [7:0] w_isr_set, w_isr_clr, w_isr_nxt;

`ifdef PIC_PRIORITY_ROTATE_EN
  level_t r_lowest_ptr;
  assign w_lowest_ptr = r_lowest_ptr;
`else
  logic w_unused_rotate;
  assign w_unused_rotate = rotate_on_eoi;
  assign w_lowest_ptr    = LOWEST_PTR_RESET;
`endif

  assign w_ack_edge = r_inta_n_q & ~inta_n;
  assign w_ack1     = (r_state == ST_IDLE) && w_ack_edge;
  assign w_ack2     = (r_state == ST_ACK1) && w_ack_edge;
  assign w_eligible = interrupt_req_register & ~interrupt_mask;

  pic_priority_encoder u_req_enc (
    .i_vec        (w_eligible),
    .i_lowest_ptr (w_lowest_ptr),
    .o_vld        (w_req_vld),
    .o_level      (w_req_level),
    .o_rank       (w_req_rank)
  );

  pic_priority_encoder u_isr_enc (
    .i_vec        (r_isr),
    .i_lowest_ptr (w_lowest_ptr),
    .o_vld        (w_isr_vld),
    .o_level      (w_isr_level),
    .o_rank       (w_isr_rank)
  );

  // Fully nested: a request must strictly outrank everything already in service.
  assign w_winner_vld = w_req_vld && (!w_isr_vld || (w_req_rank < w_isr_rank));

  assign w_aeoi_clr = w_ack2 && aeoi_mode && !r_spurious;
  assign w_eoi_clr  = eoi_cmd && !seoi_cmd && w_isr_vld;

  always_comb begin
    w_isr_set = (w_ack1 && w_winner_vld) ? level_onehot(w_req_level) : 8'h00;
    w_isr_clr = 8'h00;
    if (seoi_cmd)   w_isr_clr = w_isr_clr | level_onehot(seoi_level);
    if (w_eoi_clr)  w_isr_clr = w_isr_clr | level_onehot(w_isr_level);
    if (w_aeoi_clr) w_isr_clr = w_isr_clr | level_onehot(r_pending);
    // Set applied after clear so a coincident set/clear leaves the bit set.
    w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;
  end

  always_comb begin
    w_state_nxt = r_state;
    int_out     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        int_out = w_winner_vld;
        if (w_ack_edge) w_state_nxt = ST_ACK1;
      end
      ST_ACK1: begin
        if (w_ack_edge) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_inta_n_q   <= 1'b1;
      r_isr        <= 8'h00;
      r_clear      <= 8'h00;
      r_vector     <= 8'h00;
      r_vector_vld <= 1'b0;
      r_pending    <= '0;
      r_spurious   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_inta_n_q   <= inta_n;
      r_isr        <= w_isr_nxt;
      r_clear      <= w_isr_set;
      r_vector_vld <= w_ack2;
      if (w_ack1) begin
        r_pending  <= w_winner_vld ? w_req_level : LEVEL_SPURIOUS;
        r_spurious <= !w_winner_vld;
      end
      if (w_ack2) r_vector <= {vector_base, r_pending};
    end
  end

`ifdef PIC_PRIORITY_ROTATE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lowest_ptr <= LOWEST_PTR_RESET;
    end else if (rotate_on_eoi) begin
      if (w_aeoi_clr)     r_lowest_ptr <= r_pending;
      else if (w_eoi_clr) r_lowest_ptr <= w_isr_level;
    end
  end
`endif

  assign clear_interrupt_req = r_clear;
  assign in_service_register = r_isr;
  assign vector_out          = r_vector;
  assign vector_valid        = r_vector_vld;

endmodule

// File: tb/tb_priority_in_service.sv
// Directed, table-driven bench for priority_in_service plus hand sequences for nesting, EOI, rotation and reset.
module tb_priority_in_service;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irr, mask;
  logic       inta_n, eoi_cmd, seoi_cmd, aeoi_mode, rotate_on_eoi;
  logic [2:0] seoi_level;
  logic [4:0] vector_base;
  logic       int_out, vector_valid;
  logic [7:0] clear_req, isr, vector_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  priority_in_service dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .interrupt_req_register (irr),
    .interrupt_mask         (mask),
    .inta_n                 (inta_n),
    .eoi_cmd                (eoi_cmd),
    .seoi_cmd               (seoi_cmd),
    .seoi_level             (seoi_level),
    .aeoi_mode              (aeoi_mode),
    .rotate_on_eoi          (rotate_on_eoi),
    .vector_base            (vector_base),
    .int_out                (int_out),
    .clear_interrupt_req    (clear_req),
    .in_service_register    (isr),
    .vector_out             (vector_out),
    .vector_valid           (vector_valid)
  );

  typedef struct {
    logic [7:0] irr;
    logic [7:0] mask;
    logic [4:0] base;
    logic       aeoi;
    logic       exp_int;
    logic [7:0] exp_clr;
    logic [7:0] exp_isr1;
    logic [7:0] exp_vec;
    logic [7:0] exp_isr2;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; inta_n = 1'b1; eoi_cmd = 1'b0; seoi_cmd = 1'b0; seoi_level = 3'd0;
    aeoi_mode = 1'b0; rotate_on_eoi = 1'b0; irr = 8'h00; mask = 8'h00; vector_base = 5'h00;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // One falling edge of inta_n, seen by the DUT on the second clock.
  task automatic ack();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
  endtask

  initial begin
    tbl[0] = '{8'h24, 8'h00, 5'h08, 1'b0, 1'b1, 8'h04, 8'h04, 8'h42, 8'h04};
    tbl[1] = '{8'h00, 8'h00, 5'h08, 1'b0, 1'b0, 8'h00, 8'h00, 8'h47, 8'h00};
    tbl[2] = '{8'hF0, 8'h30, 5'h1F, 1'b0, 1'b1, 8'h40, 8'h40, 8'hFE, 8'h40};
    tbl[3] = '{8'h81, 8'h01, 5'h02, 1'b0, 1'b1, 8'h80, 8'h80, 8'h17, 8'h80};
    tbl[4] = '{8'hFF, 8'hFF, 5'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1F, 8'h00};
    tbl[5] = '{8'h01, 8'h00, 5'h00, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00};

    do_reset();
    check("reset_isr", isr, 8'h00);
    check("reset_vec", vector_out, 8'h00);
    check("reset_vv", {7'd0, vector_valid}, 8'h00);
    check("reset_clr", clear_req, 8'h00);
    check("reset_int", {7'd0, int_out}, 8'h00);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      irr = tbl[k].irr; mask = tbl[k].mask; vector_base = tbl[k].base; aeoi_mode = tbl[k].aeoi;
      #1;
      check($sformatf("t%0d_int", k), {7'd0, int_out}, {7'd0, tbl[k].exp_int});
      ack();
      check($sformatf("t%0d_clr", k), clear_req, tbl[k].exp_clr);
      check($sformatf("t%0d_isr1", k), isr, tbl[k].exp_isr1);
      check($sformatf("t%0d_int_ack1", k), {7'd0, int_out}, 8'h00);
      check($sformatf("t%0d_vv_ack1", k), {7'd0, vector_valid}, 8'h00);
      ack();
      check($sformatf("t%0d_vv", k), {7'd0, vector_valid}, 8'h01);
      check($sformatf("t%0d_vec", k), vector_out, tbl[k].exp_vec);
      check($sformatf("t%0d_isr2", k), isr, tbl[k].exp_isr2);
      check($sformatf("t%0d_clr_done", k), clear_req, 8'h00);
      tick();
      check($sformatf("t%0d_vv_pulse", k), {7'd0, vector_valid}, 8'h00);
      check($sformatf("t%0d_vec_hold", k), vector_out, tbl[k].exp_vec);
    end

    // Fully nested blocking, then a higher-priority request breaks through.
    do_reset();
    irr = 8'h04; vector_base = 5'h08;
    ack(); ack();
    check("nest_isr", isr, 8'h04);
    irr = 8'h08; #1;
    check("nest_lower_blocked", {7'd0, int_out}, 8'h00);
    irr = 8'h04; #1;
    check("nest_equal_blocked", {7'd0, int_out}, 8'h00);
    irr = 8'h02; #1;
    check("nest_higher_int", {7'd0, int_out}, 8'h01);
    ack();
    check("nest_clr", clear_req, 8'h02);
    check("nest_isr2", isr, 8'h06);
    ack();
    check("nest_vec", vector_out, 8'h41);
    irr = 8'h00;

    // Specific EOI beats a coincident non-specific EOI; EOIs on empty bits do nothing.
    seoi_cmd = 1'b1; seoi_level = 3'd2; eoi_cmd = 1'b1; tick();
    seoi_cmd = 1'b0; eoi_cmd = 1'b0;
    check("seoi_wins", isr, 8'h02);
    seoi_cmd = 1'b1; seoi_level = 3'd5; tick(); seoi_cmd = 1'b0;
    check("seoi_noop", isr, 8'h02);
    eoi_cmd = 1'b1; tick(); eoi_cmd = 1'b0;
    check("eoi_clear", isr, 8'h00);
    eoi_cmd = 1'b1; tick(); eoi_cmd = 1'b0;
    check("eoi_empty", isr, 8'h00);

    // Set and clear on the same bit in one cycle leave it set.
    do_reset();
    irr = 8'h02;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; seoi_cmd = 1'b1; seoi_level = 3'd1; tick();
    seoi_cmd = 1'b0;
    check("set_clr_same", isr, 8'h02);

    // Rotation on non-specific EOI (ignored in the default build).
    do_reset();
    irr = 8'h10;
    ack(); ack();
    irr = 8'h00;
    check("rot_isr", isr, 8'h10);
    rotate_on_eoi = 1'b1; eoi_cmd = 1'b1; tick(); eoi_cmd = 1'b0;
    check("rot_eoi_isr", isr, 8'h00);
    irr = 8'h21; #1;
    check("rot_int", {7'd0, int_out}, 8'h01);
    ack();
`ifdef PIC_PRIORITY_ROTATE_EN
    check("rot_winner", clear_req, 8'h20);
`else
    check("rot_winner", clear_req, 8'h01);
`endif
    rotate_on_eoi = 1'b0;

    // Reset between the two acknowledges.
    do_reset();
    irr = 8'h04; vector_base = 5'h08;
    ack();
    check("rst_mid_isr_pre", isr, 8'h04);
    reset_n = 1'b0; inta_n = 1'b1; #2;
    check("rst_mid_isr", isr, 8'h00);
    check("rst_mid_clr", clear_req, 8'h00);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rst_mid_vv_%0d", c), {7'd0, vector_valid}, 8'h00);
    end
    check("rst_mid_idle_int", {7'd0, int_out}, 8'h01);
    ack();
    check("rst_mid_reack_vv", {7'd0, vector_valid}, 8'h00);
    check("rst_mid_reack_isr", isr, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_in_service.md
PRIORITY_IN_SERVICE -- requirements
Module: priority_in_service

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 interrupt_req_register  input  8  pending requests from the IRR stage.
REQ-004 interrupt_mask  input  8  OCW1 mask; 1 masks that level.
REQ-005 inta_n  input  1  CPU acknowledge, active-low; two low pulses per cycle; sampled on clk.
REQ-006 eoi_cmd  input  1  one-cycle non-specific EOI strobe.
REQ-007 seoi_cmd  input  1  one-cycle specific EOI strobe.
REQ-008 seoi_level  input  3  level cleared by seoi_cmd.
REQ-009 aeoi_mode  input  1  1 = automatic EOI on second acknowledge.
REQ-010 rotate_on_eoi  input  1  1 = non-specific EOI also rotates priority (ROTATE_EN builds only).
REQ-011 vector_base  input  5  T7..T3 of the vector byte.
REQ-012 int_out  output  1  interrupt request to CPU.
REQ-013 clear_interrupt_req  output  8  one-cycle one-hot pulse to the IRR stage.
REQ-014 in_service_register  output  8  ISR contents.
REQ-015 vector_out  output  8  {vector_base, level}.
REQ-016 vector_valid  output  1  one-cycle strobe qualifying vector_out.

Function
REQ-017 Acknowledge edge = inta_n sampled 1 last cycle, 0 this cycle; one internal register holds the previous sample.
REQ-018 Eligible = interrupt_req_register & ~interrupt_mask.
REQ-019 Priority: level (lowest_ptr+1) mod 8 highest, descending cyclically; lowest_ptr fixed at 7 when rotation is absent or unused.
REQ-020 Winner = highest-priority eligible level strictly above the highest-priority ISR bit (fully nested); equal or lower levels are blocked.
REQ-021 int_out = 1 combinationally when a winner exists and state is IDLE; 0 in ACK1.
REQ-022 FSM states IDLE, ACK1; IDLE --ack edge--> ACK1; ACK1 --ack edge--> IDLE; no other transitions.
REQ-023 On the first ack edge with a winner: latch winner into pending_level, set its ISR bit, pulse clear_interrupt_req[winner] for exactly that cycle.
REQ-024 On the first ack edge with no winner (spurious): pending_level = 7, ISR unchanged, no clear pulse.
REQ-025 Second ack edge: vector_valid = 1 for one cycle, vector_out = {vector_base, pending_level}; if aeoi_mode and not spurious, clear ISR[pending_level] the same cycle.
REQ-026 eoi_cmd: clear highest-priority set ISR bit; no effect if ISR is 0.
REQ-027 seoi_cmd: clear ISR[seoi_level]; no effect if already 0.
REQ-028 eoi_cmd and seoi_cmd together: seoi_cmd wins, eoi_cmd is ignored.
REQ-029 EOI coinciding with an ISR set: both apply; a set and a clear on the same bit leave the bit set.
REQ-030 vector_out holds its value between strobes.

Reset
REQ-031 While reset_n = 0: state IDLE; ISR, clear_interrupt_req, vector_out, vector_valid, pending_level = 0; lowest_ptr = 7; inta_n sample register = 1.
REQ-032 Reset mid-acknowledge returns to IDLE without a vector strobe or a clear pulse.

Configuration
REQ-033 Macro PIC_PRIORITY_ROTATE_EN defined: a non-specific EOI with rotate_on_eoi = 1 sets lowest_ptr to the cleared level; an AEOI with rotate_on_eoi = 1 sets lowest_ptr to pending_level.
REQ-034 PIC_PRIORITY_ROTATE_EN undefined: rotate_on_eoi is ignored, lowest_ptr is the constant 7, and no rotation logic is generated.

Structure
REQ-035 Shared package pic_pkg holds the FSM state enum, the level typedef (3 bits), and LOWEST_PTR_RESET = 7.
REQ-036 One sub-module, pic_priority_encoder (combinational, rotated one-hot-to-level), is instantiated twice: once for the request winner, once for the highest ISR bit.

Verification
REQ-037 IRR = 0x24, mask = 0, two acknowledges, vector_base = 0x08 -> ISR = 0x04, clear_interrupt_req = 0x04 pulse, vector_out = 0x42.
REQ-038 ISR = 0x04, IRR = 0x08 -> int_out = 0; set IRR = 0x02 -> int_out = 1, winner 1.
REQ-039 No request, two acknowledges -> vector_out = {vector_base, 3'd7}, ISR unchanged, no clear pulse.
REQ-040 aeoi_mode = 1, IRR = 0x01, two acknowledges -> ISR = 0x01 after ACK1, 0x00 after second edge.
REQ-041 ROTATE_EN build, ISR = 0x10, eoi_cmd with rotate_on_eoi = 1 -> ISR = 0, lowest_ptr = 4; IRR = 0x21 -> winner 5.
REQ-042 reset_n low between acknowledges -> IDLE, vector_valid never asserted, ISR = 0.
